// File: rtl/spi_slave.sv
// SPI slave, mode set by SPI_MODE, oversampled on clk_i. Define SPI_SLAVE_UNDERRUN_DET_EN
// to get a tx_underrun_o pulse when a byte start finds the holding register empty.
//
// state     | meaning
// ST_IDLE   | CS high: MISO disabled and driven 0, SPI clock edges ignored
// ST_ACTIVE | CS low: sampling MOSI, shifting MISO
module spi_slave #(
    parameter int SPI_MODE = 0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] tx_data_byte_i,
    input  logic       tx_data_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_byte_o,
    output logic       rx_data_valid_o,
    input  logic       spi_clk_i,
    input  logic       spi_cs_n_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oe_o,
    output logic       tx_underrun_o
);

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t     state, state_nxt;
    logic       sclk_meta, sclk_sync, sclk_prev;
    logic       cs_meta, cs_sync, cs_prev;
    logic       mosi_meta, mosi_sync;
    logic       hold_full;
    logic [7:0] hold_data;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [2:0] bit_cnt;
    logic       miso_q;
    logic       cs_fall, cs_rise, lead_edge, trail_edge;
    logic       edges_en, sample_edge, shift_edge, byte_start, tx_accept;
    logic [7:0] load_byte;

    // Synchronizers idle at bus-idle levels so releasing reset never fakes an edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sclk_meta <= CPOL;
            sclk_sync <= CPOL;
            sclk_prev <= CPOL;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sclk_meta <= spi_clk_i;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            cs_meta   <= spi_cs_n_i;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            mosi_meta <= spi_mosi_i;
            mosi_sync <= mosi_meta;
        end
    end

    assign cs_fall     = cs_prev & ~cs_sync;
    assign cs_rise     = ~cs_prev & cs_sync;
    assign lead_edge   = (sclk_prev == CPOL) && (sclk_sync != CPOL);
    assign trail_edge  = (sclk_prev != CPOL) && (sclk_sync == CPOL);
    assign edges_en    = (state == ST_ACTIVE) && !cs_rise;
    assign sample_edge = edges_en && (CPHA ? trail_edge : lead_edge);
    assign shift_edge  = edges_en && (CPHA ? lead_edge : trail_edge);
    assign byte_start  = ((state == ST_IDLE) && cs_fall) || (sample_edge && (bit_cnt == 3'd7));
    assign tx_accept   = tx_data_valid_i && !hold_full;
    assign load_byte   = hold_full ? hold_data : 8'h00;
    assign tx_ready_o  = ~hold_full;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (cs_fall) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        spi_miso_oe_o = (state == ST_ACTIVE);
    end

    // A byte start only ever sees the register as it was; a same-cycle accept waits for the next start.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hold_full <= 1'b0;
            hold_data <= 8'h00;
        end else begin
            if (byte_start) hold_full <= 1'b0;
            if (tx_accept) begin
                hold_full <= 1'b1;
                hold_data <= tx_data_byte_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tx_shift        <= 8'h00;
            rx_shift        <= 8'h00;
            bit_cnt         <= 3'd0;
            miso_q          <= 1'b0;
            rx_data_byte_o  <= 8'h00;
            rx_data_valid_o <= 1'b0;
        end else begin
            rx_data_valid_o <= 1'b0;
            if ((state == ST_ACTIVE) && cs_rise) begin
                tx_shift <= 8'h00;
                rx_shift <= 8'h00;
                bit_cnt  <= 3'd0;
                miso_q   <= 1'b0;
            end else begin
                if (sample_edge) begin
                    rx_shift <= {rx_shift[6:0], mosi_sync};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data_byte_o  <= {rx_shift[6:0], mosi_sync};
                        rx_data_valid_o <= 1'b1;
                    end
                end
                // With CPHA=0 the trailing edge right after a byte boundary must not shift the fresh byte.
                if (byte_start) begin
                    tx_shift <= load_byte;
                    if (!CPHA) miso_q <= load_byte[7];
                end else if (shift_edge && (CPHA || (bit_cnt != 3'd0))) begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                    miso_q   <= CPHA ? tx_shift[7] : tx_shift[6];
                end
            end
        end
    end

    assign spi_miso_o = miso_q;

`ifdef SPI_SLAVE_UNDERRUN_DET_EN
    logic underrun_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) underrun_q <= 1'b0;
        else         underrun_q <= byte_start && !hold_full;
    end

    assign tx_underrun_o = underrun_q;
`else
    assign tx_underrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, a bit-level SPI master and a byte-level
// reference model (expected rx queue, holding-register bookkeeping, underrun counts).
module tb_spi_slave;

    logic       clk_i;
    logic       reset_i;
    logic [7:0] tx_byte [4];
    logic [7:0] rx_byte [4];
    logic [3:0] tx_valid, tx_ready, rx_valid;
    logic [3:0] sclk, cs_n, mosi, miso, miso_oe, underrun;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.SPI_MODE(g)) u_dut (
            .clk_i          (clk_i),
            .reset_i        (reset_i),
            .tx_data_byte_i (tx_byte[g]),
            .tx_data_valid_i(tx_valid[g]),
            .tx_ready_o     (tx_ready[g]),
            .rx_data_byte_o (rx_byte[g]),
            .rx_data_valid_o(rx_valid[g]),
            .spi_clk_i      (sclk[g]),
            .spi_cs_n_i     (cs_n[g]),
            .spi_mosi_i     (mosi[g]),
            .spi_miso_o     (miso[g]),
            .spi_miso_oe_o  (miso_oe[g]),
            .tx_underrun_o  (underrun[g])
        );
    end

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int         checks = 0;
    int         errors = 0;
    int         active = 0;
    logic [7:0] exp_rx[$];
    int         rxv_cnt[4];
    int         und_cnt[4];
    int         exp_und[4];
    int         cs_stable[4];
    logic [3:0] cs_seen;
    logic       prev_v[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 4; i++) begin
                cs_stable[i] = 0;
                prev_v[i]    = 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cs_n[i] !== cs_seen[i]) begin
                    cs_seen[i]   = cs_n[i];
                    cs_stable[i] = 0;
                end else if (cs_stable[i] < 1000) begin
                    cs_stable[i]++;
                end
                if (cs_stable[i] >= 5) begin
                    chk("miso_oe", {31'd0, miso_oe[i]}, {31'd0, ~cs_n[i]});
                    if (cs_n[i]) chk("miso_idle", {31'd0, miso[i]}, 32'd0);
                end
                if (rx_valid[i]) begin
                    rxv_cnt[i]++;
                    chk("rx_pulse_width", {31'd0, prev_v[i]}, 32'd0);
                    if (i != active || exp_rx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: inst %0d got byte %0h expected no pulse", i, rx_byte[i]);
                    end else begin
                        logic [7:0] e;
                        e = exp_rx.pop_front();
                        chk("rx_byte", {24'd0, rx_byte[i]}, {24'd0, e});
                    end
                end
                if (underrun[i]) und_cnt[i]++;
                prev_v[i] = rx_valid[i];
            end
        end
    end

    task automatic load_tx(input int m, input logic [7:0] v);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!tx_ready[m] && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!tx_ready[m]) begin
            checks++;
            errors++;
            $display("FAIL tx_ready_timeout: inst %0d got ready 0 expected 1", m);
        end else begin
            tx_byte[m]  = v;
            tx_valid[m] = 1'b1;
            @(negedge clk_i);
            tx_valid[m] = 1'b0;
        end
    endtask

    // Bit-level master: drives MOSI MSb first, captures MISO at each sample edge.
    task automatic spi_xfer(input int m, input logic [15:0] mw, input int nbits, input int half,
                            output logic [15:0] got, output logic pre);
        logic cpol, cpha;
        cpol = (m >= 2);
        cpha = (m % 2) == 1;
        got  = 16'h0000;
        pre  = 1'b0;
        @(posedge clk_i);
        #3;
        sclk[m] = cpol;
        mosi[m] = cpha ? 1'b0 : mw[15];
        cs_n[m] = 1'b0;
        #80;
        for (int b = 0; b < nbits; b++) begin
            if (!cpha) begin
                got[15-b] = miso[m];
                if (b % 8 == 7) exp_rx.push_back(8'(mw >> (15 - b)));
                sclk[m] = ~cpol;
                #(half);
                sclk[m] = cpol;
                if (b + 1 < nbits) mosi[m] = mw[14-b];
                #(half);
            end else begin
                if (b == 0) pre = miso[m];
                mosi[m] = mw[15-b];
                sclk[m] = ~cpol;
                #(half);
                got[15-b] = miso[m];
                if (b % 8 == 7) exp_rx.push_back(8'(mw >> (15 - b)));
                sclk[m] = cpol;
                #(half);
            end
        end
    endtask

    task automatic run_xfer(input int m, input bit pre, input logic [7:0] pv, input bit feed,
                            input logic [7:0] fv, input logic [15:0] mw, input int nbits,
                            input int half, input bit do_reset, output logic [15:0] got);
        logic [15:0] expw, mask;
        logic        pre_m;
        active = m;
        expw   = {pre ? pv : 8'h00, feed ? fv : 8'h00};
        mask   = ~(16'hFFFF >> nbits);
`ifdef SPI_SLAVE_UNDERRUN_DET_EN
        exp_und[m] += (pre ? 0 : 1) + ((nbits >= 8 && !feed) ? 1 : 0) + ((nbits >= 16) ? 1 : 0);
`endif
        if (pre) load_tx(m, pv);
        fork
            spi_xfer(m, mw, nbits, half, got, pre_m);
            begin
                if (feed) begin
                    #100;
                    load_tx(m, fv);
                end
            end
        join
        if (do_reset) begin
            @(negedge clk_i);
            reset_i = 1'b1;
            repeat (2) @(negedge clk_i);
            for (int i = 0; i < 4; i++) begin
                chk("rst_tx_ready", {31'd0, tx_ready[i]}, 32'd1);
                chk("rst_rx_byte", {24'd0, rx_byte[i]}, 32'h00);
                chk("rst_rx_valid", {31'd0, rx_valid[i]}, 32'd0);
                chk("rst_miso", {31'd0, miso[i]}, 32'd0);
                chk("rst_miso_oe", {31'd0, miso_oe[i]}, 32'd0);
                chk("rst_underrun", {31'd0, underrun[i]}, 32'd0);
            end
            cs_n[m] = 1'b1;
            sclk[m] = (m >= 2);
            mosi[m] = 1'b0;
            @(negedge clk_i);
            reset_i = 1'b0;
            exp_rx.delete();
        end else begin
            cs_n[m] = 1'b1;
            mosi[m] = 1'b0;
        end
        repeat (12) @(negedge clk_i);
        chk("miso_data", {16'd0, got & mask}, {16'd0, expw & mask});
        chk("rx_missing", exp_rx.size(), 32'd0);
        chk("underrun_count", und_cnt[m], exp_und[m]);
        chk("tx_ready_idle", {31'd0, tx_ready[m]}, 32'd1);
        if (m % 2 == 1) chk("miso_before_lead", {31'd0, pre_m}, 32'd0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got;
        int          c0, u0, exp_one;
        reset_i  = 1'b1;
        cs_n     = 4'hF;
        mosi     = 4'h0;
        tx_valid = 4'h0;
        cs_seen  = 4'hF;
        for (int i = 0; i < 4; i++) begin
            sclk[i]    = (i >= 2);
            tx_byte[i] = 8'h00;
            rxv_cnt[i] = 0;
            und_cnt[i] = 0;
            exp_und[i] = 0;
            prev_v[i]  = 1'b0;
        end
        repeat (3) @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            chk("init_tx_ready", {31'd0, tx_ready[i]}, 32'd1);
            chk("init_rx_byte", {24'd0, rx_byte[i]}, 32'h00);
            chk("init_rx_valid", {31'd0, rx_valid[i]}, 32'd0);
            chk("init_miso_oe", {31'd0, miso_oe[i]}, 32'd0);
            chk("init_underrun", {31'd0, underrun[i]}, 32'd0);
        end
        reset_i = 1'b0;
        repeat (3) @(negedge clk_i);

        // Mode 0 single byte.
        c0 = rxv_cnt[0];
        run_xfer(0, 1'b1, 8'hA5, 1'b0, 8'h00, 16'h3C00, 8, 40, 1'b0, got);
        chk("m0_miso", {24'd0, got[15:8]}, 32'hA5);
        chk("m0_rx", {24'd0, rx_byte[0]}, 32'h3C);
        chk("m0_pulses", rxv_cnt[0] - c0, 32'd1);

        // Modes 1..3.
        for (int m = 1; m < 4; m++) begin
            run_xfer(m, 1'b1, 8'h96, 1'b0, 8'h00, 16'h6900, 8, 40, 1'b0, got);
            chk("mode_miso", {24'd0, got[15:8]}, 32'h96);
            chk("mode_rx", {24'd0, rx_byte[m]}, 32'h69);
        end

        // Back-to-back bytes under continuous CS.
        c0 = rxv_cnt[0];
        run_xfer(0, 1'b1, 8'h11, 1'b1, 8'h22, 16'hF00F, 16, 40, 1'b0, got);
        chk("b2b_miso", {16'd0, got}, 32'h1122);
        chk("b2b_pulses", rxv_cnt[0] - c0, 32'd2);
        chk("b2b_rx_last", {24'd0, rx_byte[0]}, 32'h0F);

        // Underrun at CS fall; the fed byte covers the second byte start.
        u0 = und_cnt[0];
`ifdef SPI_SLAVE_UNDERRUN_DET_EN
        exp_one = 1;
`else
        exp_one = 0;
`endif
        run_xfer(0, 1'b0, 8'h00, 1'b1, 8'h77, 16'h5500, 8, 50, 1'b0, got);
        chk("underrun_miso", {24'd0, got[15:8]}, 32'h00);
        chk("underrun_pulses", und_cnt[0] - u0, exp_one);

        // CS abort after 5 bits, then a full byte.
        c0 = rxv_cnt[0];
        run_xfer(0, 1'b1, 8'h3E, 1'b0, 8'h00, 16'hC300, 5, 45, 1'b0, got);
        chk("abort_pulses", rxv_cnt[0] - c0, 32'd0);
        run_xfer(0, 1'b1, 8'h42, 1'b0, 8'h00, 16'h8100, 8, 45, 1'b0, got);
        chk("after_abort_rx", {24'd0, rx_byte[0]}, 32'h81);

        // Reset after 4 bits, then a clean transfer.
        run_xfer(0, 1'b1, 8'hD2, 1'b0, 8'h00, 16'hF000, 4, 40, 1'b1, got);
        run_xfer(0, 1'b1, 8'hE7, 1'b0, 8'h00, 16'h5A00, 8, 40, 1'b0, got);
        chk("post_reset_miso", {24'd0, got[15:8]}, 32'hE7);
        chk("post_reset_rx", {24'd0, rx_byte[0]}, 32'h5A);

        // Randomized transfers.
        for (int t = 0; t < 40; t++) begin
            int   m, nb, half, sel;
            bit   pre, feed;
            m    = $urandom_range(0, 3);
            sel  = $urandom_range(0, 4);
            nb   = (sel == 0) ? 8 : (sel == 1) ? 16 : (sel == 2) ? 5 : (sel == 3) ? 3 : 12;
            pre  = ($urandom_range(0, 3) != 0);
            feed = (nb >= 8) && ($urandom_range(0, 1) == 1);
            half = $urandom_range(4, 6) * 10 + $urandom_range(0, 3);
            run_xfer(m, pre, 8'($urandom), feed, 8'($urandom), 16'($urandom), nb, half, 1'b0, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
